index_dump_serializer: RTL and testbench

- Downstream consumer of the single-cycle processor's ten 64-bit data-memory observation outputs (Index_0..Index_9).
- On a start request it snapshots all words and streams them as a framed byte sequence over a valid/ready byte interface, for a UART or debug-link transmitter.
- Frame layout: sync byte, data bytes little-endian (word 0 first), XOR checksum byte.

---
 rtl/dump_pkg.sv | 22 ++
 rtl/index_dump_serializer.sv | 84 ++++++++
 tb/tb_index_dump_serializer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dump_pkg.sv
// Shared constants and state encoding for the index dump serializer.
// Default frame geometry matches the processor's ten 64-bit observation words.
package dump_pkg;

  localparam int          NUM_WORDS_D    = 10;
  localparam int          WORD_W_D       = 64;
  localparam logic [7:0]  SYNC_BYTE_D    = 8'hA5;
  localparam int          BYTES_PER_WORD = WORD_W_D / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CHK  = 2'd3
  } state_t;

  // Counter width that never collapses to zero bits for tiny frames.
  function automatic int cnt_w(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/index_dump_serializer.sv
// Snapshots NUM_WORDS words on start and streams them as a framed byte sequence:
// SYNC, data bytes little-endian (word 0 first), XOR checksum of the data bytes.
module index_dump_serializer
  import dump_pkg::*;
#(
  parameter int          NUM_WORDS = NUM_WORDS_D,
  parameter int          WORD_W    = WORD_W_D,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_D
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_WORDS*WORD_W-1:0] idx_flat,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int             NBYTES = NUM_WORDS * WORD_W / 8;
  localparam int             CW     = cnt_w(NBYTES);
  localparam logic [CW-1:0]  LAST   = CW'(NBYTES - 1);

  state_t                    r_state;
  state_t                    w_state_nx;
  logic [NBYTES-1:0][7:0]    r_snap;
  logic [CW-1:0]             r_cnt;
  logic [7:0]                r_csum;
  logic                      r_done;
  logic                      w_hs;
  logic [7:0]                w_byte;

  assign w_hs     = tx_valid && tx_ready;
  assign w_byte   = r_snap[r_cnt];
  assign tx_valid = (r_state != IDLE);
  assign busy     = (r_state != IDLE);
  assign done     = r_done;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE: if (start)                  w_state_nx = HDR;
      HDR:  if (w_hs)                   w_state_nx = DATA;
      DATA: if (w_hs && r_cnt == LAST)  w_state_nx = CHK;
      CHK:  if (w_hs)                   w_state_nx = IDLE;
      default:                          w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    tx_data = 8'h00;
    case (r_state)
      HDR:     tx_data = SYNC_BYTE;
      DATA:    tx_data = w_byte;
      CHK:     tx_data = r_csum;
      default: tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_snap  <= '0;
      r_cnt   <= '0;
      r_csum  <= 8'h00;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_done  <= (r_state == CHK) && w_hs;
      // Capture happens on the acceptance edge so later input changes cannot leak in.
      if (r_state == IDLE && start) begin
        r_snap <= idx_flat;
        r_cnt  <= '0;
        r_csum <= 8'h00;
      end
      if (r_state == DATA && w_hs) begin
        r_csum <= r_csum ^ w_byte;
        if (r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_index_dump_serializer.sv
// Bench for index_dump_serializer: queue-based frame model checked every cycle,
// plus literal byte/timing expectations for each directed scenario.
module tb_index_dump_serializer;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [639:0] idx_flat;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  bit chk_en = 0;

  byte unsigned mq[$];
  bit           m_done = 0;
  byte unsigned cap[$];
  int           cap_cyc[$];

  index_dump_serializer dut (
    .clk(clk), .reset(reset), .start(start), .idx_flat(idx_flat),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: a frame is just a queue of bytes built at acceptance; pop one per ready cycle.
  always @(posedge clk) begin : model
    byte unsigned x;
    cyc++;
    if (reset) begin
      mq.delete();
      m_done = 0;
    end else if (mq.size() != 0) begin
      m_done = 0;
      if (tx_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_done = 1;
      end
    end else begin
      m_done = 0;
      if (start) begin
        x = 0;
        mq.push_back(8'hA5);
        for (int i = 0; i < 80; i++) begin
          mq.push_back(idx_flat[i*8 +: 8]);
          x = x ^ idx_flat[i*8 +: 8];
        end
        mq.push_back(x);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk($sformatf("tx_valid@%0d", cyc), tx_valid, mq.size() != 0);
      chk($sformatf("busy@%0d", cyc), busy, mq.size() != 0);
      chk($sformatf("done@%0d", cyc), done, m_done);
      if (mq.size() != 0) chk($sformatf("tx_data@%0d", cyc), tx_data, mq[0]);
      if (tx_valid && tx_ready) begin
        cap.push_back(tx_data);
        cap_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int bound);
    int k;
    k = 0;
    while (done_cnt < n && k < bound) begin
      step(1);
      k++;
    end
    chk("done_wait", done_cnt >= n, 1);
    step(2);
  endtask

  task automatic set_basic();
    idx_flat = '0;
    idx_flat[63:0] = 64'h0123456789ABCDEF;
  endtask

  task automatic clear_cap();
    cap.delete();
    cap_cyc.delete();
  endtask

  initial begin : stim
    byte unsigned exp9[9];
    int  base;
    int  k;
    bit  found;
    exp9 = '{8'hA5, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};

    reset = 1'b1; start = 1'b0; tx_ready = 1'b1; idx_flat = '0;
    step(2);
    chk("rst_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", tx_data, 0);
    reset = 1'b0;
    chk_en = 1;
    step(2);

    // Basic frame
    set_basic(); clear_cap(); base = done_cnt;
    pulse_start();
    wait_done(base + 1, 200);
    chk("basic_len", cap.size(), 82);
    if (cap.size() == 82) begin
      for (int i = 0; i < 9; i++) chk($sformatf("basic_b%0d", i), cap[i], exp9[i]);
      chk("basic_b40", cap[40], 0);
      chk("basic_csum", cap[81], 0);
      chk("basic_span", cap_cyc[81] - cap_cyc[0], 81);
      chk("basic_done_lat", last_done_cyc - cap_cyc[81], 1);
    end

    // Last word ordering and checksum
    idx_flat = '0; idx_flat[9*64 +: 64] = 64'h00000000000000FF;
    clear_cap(); base = done_cnt;
    pulse_start();
    wait_done(base + 1, 200);
    chk("w9_len", cap.size(), 82);
    if (cap.size() == 82) begin
      chk("w9_b72", cap[72], 0);
      chk("w9_b73", cap[73], 8'hFF);
      for (int i = 74; i <= 80; i++) chk($sformatf("w9_b%0d", i), cap[i], 0);
      chk("w9_csum", cap[81], 8'hFF);
    end

    // Backpressure on the CD byte
    set_basic(); clear_cap(); base = done_cnt;
    pulse_start();
    found = 0;
    k = 0;
    while (!found && k < 20) begin
      if (tx_valid && tx_data == 8'hCD) found = 1;
      else begin step(1); k++; end
    end
    chk("bp_found", found, 1);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_hold_data%0d", i), tx_data, 8'hCD);
      chk($sformatf("bp_hold_valid%0d", i), tx_valid, 1);
      step(1);
    end
    tx_ready = 1'b1;
    wait_done(base + 1, 200);
    chk("bp_len", cap.size(), 82);
    if (cap.size() == 82) begin
      chk("bp_b2", cap[2], 8'hCD);
      chk("bp_b3", cap[3], 8'hAB);
      chk("bp_span", cap_cyc[81] - cap_cyc[0] + 1, 85);
    end

    // Snapshot isolation and start ignored while busy
    set_basic(); clear_cap(); base = done_cnt;
    pulse_start();
    step(10);
    idx_flat[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done(base + 1, 200);
    step(5);
    chk("snap_done_cnt", done_cnt, base + 1);
    chk("snap_len", cap.size(), 82);
    if (cap.size() == 82) begin
      chk("snap_b1", cap[1], 8'hEF);
      chk("snap_b2", cap[2], 8'hCD);
      chk("snap_csum", cap[81], 0);
    end

    // Reset during data byte 20
    set_basic(); clear_cap();
    pulse_start();
    k = 0;
    while (cap.size() < 21 && k < 100) begin
      step(1);
      k++;
    end
    chk("rstmid_reach", cap.size() >= 21, 1);
    base = done_cnt;
    reset = 1'b1;
    step(1);
    chk("rstmid_valid", tx_valid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_data", tx_data, 0);
    reset = 1'b0;
    step(2);
    chk("rstmid_no_done", done_cnt, base);
    clear_cap();
    pulse_start();
    wait_done(base + 1, 200);
    chk("rstmid_len", cap.size(), 82);
    if (cap.size() == 82) begin
      chk("rstmid_b0", cap[0], 8'hA5);
      chk("rstmid_b1", cap[1], 8'hEF);
    end

    // Back-to-back with start held high
    set_basic(); clear_cap(); base = done_cnt;
    start = 1'b1;
    wait_done(base + 2, 400);
    start = 1'b0;
    k = 0;
    while (busy && k < 200) begin
      step(1);
      k++;
    end
    chk("b2b_idle", busy, 0);
    step(3);
    chk("b2b_len", cap.size() >= 164, 1);
    if (cap.size() >= 164) begin
      chk("b2b_f1_csum", cap[81], 0);
      chk("b2b_f2_sync", cap[82], 8'hA5);
      chk("b2b_gap", cap_cyc[82] - cap_cyc[81], 2);
      chk("b2b_f2_csum", cap[163], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
